// File: rtl/gb_mapper_pkg.sv
// Shared types and constants for the MBC1-class cartridge mapper: bus regions, window bases, open-bus value.
package gb_mapper_pkg;

  typedef enum logic [2:0] {
    RGN_ROM0,
    RGN_ROMX,
    RGN_VRAM,
    RGN_SRAM,
    RGN_WRAM,
    RGN_HI
  } region_t;

  localparam logic [15:0] ADDR_ROMX  = 16'h4000;
  localparam logic [15:0] ADDR_VRAM  = 16'h8000;
  localparam logic [15:0] ADDR_SRAM  = 16'hA000;
  localparam logic [15:0] ADDR_WRAM  = 16'hC000;
  localparam logic [15:0] ADDR_HI    = 16'hFE00;
  localparam logic [7:0]  OPEN_BUS   = 8'hFF;
  localparam logic [3:0]  RAM_EN_KEY = 4'hA;

  // Register select is A[14:13] within 0000-7FFF.
  localparam logic [1:0] REG_RAM_EN  = 2'd0;
  localparam logic [1:0] REG_BANK_LO = 2'd1;
  localparam logic [1:0] REG_BANK_HI = 2'd2;
  localparam logic [1:0] REG_MODE    = 2'd3;

  function automatic region_t decode_region(input logic [15:0] a);
    region_t r;
    if (a < ADDR_ROMX)      r = RGN_ROM0;
    else if (a < ADDR_VRAM) r = RGN_ROMX;
    else if (a < ADDR_SRAM) r = RGN_VRAM;
    else if (a < ADDR_WRAM) r = RGN_SRAM;
    else if (a < ADDR_HI)   r = RGN_WRAM;
    else                    r = RGN_HI;
    return r;
  endfunction

endpackage

// File: rtl/gb_mapper_regs.sv
// Write-strobe edge detector and MBC1 bank registers; commit is combinational, registers update on that edge.
// GB_MAPPER_DBG_EN adds a 16-bit wrapping count of register commits.
module gb_mapper_regs
  import gb_mapper_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        cs_n,
  input  logic        wr_n,
  input  logic [2:0]  a_hi,
  input  logic [4:0]  wdat,
  output logic        commit,
  output logic        ram_en,
  output logic [4:0]  bank_lo,
  output logic [1:0]  bank_hi,
  output logic        mode
`ifdef GB_MAPPER_DBG_EN
  ,
  output logic [15:0] wr_cnt
`endif
);

  logic       wr_q, wr_d;
  logic       ram_en_q, ram_en_d;
  logic [4:0] bank_lo_q, bank_lo_d;
  logic [1:0] bank_hi_q, bank_hi_d;
  logic       mode_q, mode_d;
  logic       reg_wr;
`ifdef GB_MAPPER_DBG_EN
  logic [15:0] wr_cnt_q, wr_cnt_d;
`endif

  always_comb begin
    // Gated by reset so no strobe escapes while the block is held in reset.
    commit    = !reset && !cs_n && !wr_n && wr_q;
    reg_wr    = commit && !a_hi[2];
    wr_d      = wr_n;
    ram_en_d  = ram_en_q;
    bank_lo_d = bank_lo_q;
    bank_hi_d = bank_hi_q;
    mode_d    = mode_q;
    if (reg_wr) begin
      case (a_hi[1:0])
        REG_RAM_EN:  ram_en_d  = (wdat[3:0] == RAM_EN_KEY);
        REG_BANK_LO: bank_lo_d = (wdat == 5'd0) ? 5'd1 : wdat;
        REG_BANK_HI: bank_hi_d = wdat[1:0];
        REG_MODE:    mode_d    = wdat[0];
        default:     ;
      endcase
    end
`ifdef GB_MAPPER_DBG_EN
    wr_cnt_d = reg_wr ? wr_cnt_q + 16'd1 : wr_cnt_q;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q      <= 1'b1;
      ram_en_q  <= 1'b0;
      bank_lo_q <= 5'd1;
      bank_hi_q <= 2'd0;
      mode_q    <= 1'b0;
`ifdef GB_MAPPER_DBG_EN
      wr_cnt_q  <= 16'd0;
`endif
    end else begin
      wr_q      <= wr_d;
      ram_en_q  <= ram_en_d;
      bank_lo_q <= bank_lo_d;
      bank_hi_q <= bank_hi_d;
      mode_q    <= mode_d;
`ifdef GB_MAPPER_DBG_EN
      wr_cnt_q  <= wr_cnt_d;
`endif
    end
  end

  assign ram_en  = ram_en_q;
  assign bank_lo = bank_lo_q;
  assign bank_hi = bank_hi_q;
  assign mode    = mode_q;
`ifdef GB_MAPPER_DBG_EN
  assign wr_cnt  = wr_cnt_q;
`endif

endmodule

// File: rtl/gb_cart_mapper.sv
// MBC1-class mapper: banked ROM/SRAM and echo-aware WRAM decode; addresses and Di are combinational,
// write strobes last one cycle per bus write. GB_MAPPER_DBG_EN exposes bank state and a commit counter.
module gb_cart_mapper
  import gb_mapper_pkg::*;
#(
  parameter  int ROM_BANKS = 128,
  parameter  int RAM_BANKS = 4,
  localparam int ROM_AW    = $clog2(ROM_BANKS) + 14,
  localparam int RAM_AW    = ((RAM_BANKS > 1) ? $clog2(RAM_BANKS) : 1) + 13
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       A,
  input  logic [7:0]        Do,
  input  logic              wr_n,
  input  logic              rd_n,
  input  logic              cs_n,
  output logic [7:0]        Di,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [7:0]        ram_data,
  output logic              ram_we,
  output logic [12:0]       wram_addr,
  input  logic [7:0]        wram_data,
  output logic              wram_we
`ifdef GB_MAPPER_DBG_EN
  ,
  output logic [6:0]        dbg_rom_bank,
  output logic              dbg_ram_en,
  output logic              dbg_mode,
  output logic [15:0]       dbg_wr_cnt
`endif
);

  localparam logic [1:0] RAM_MASK = (RAM_BANKS > 1) ? 2'(RAM_BANKS - 1) : 2'd0;
  localparam bit         HAS_SRAM = (RAM_BANKS != 0);

  region_t    rgn;
  logic       commit;
  logic       ram_en;
  logic [4:0] bank_lo;
  logic [1:0] bank_hi;
  logic       mode;
  logic [6:0] rom_bank;
  logic [20:0] rom_full;
  logic [1:0] ram_bank;
  logic       sram_on;
  logic       unused_do;

  assign unused_do = ^Do[7:5];

  gb_mapper_regs u_regs (
    .clock   (clock),
    .reset   (reset),
    .cs_n    (cs_n),
    .wr_n    (wr_n),
    .a_hi    (A[15:13]),
    .wdat    (Do[4:0]),
    .commit  (commit),
    .ram_en  (ram_en),
    .bank_lo (bank_lo),
    .bank_hi (bank_hi),
    .mode    (mode)
`ifdef GB_MAPPER_DBG_EN
    ,
    .wr_cnt  (dbg_wr_cnt)
`endif
  );

  always_comb begin
    rgn = decode_region(A);
    // Mode 1 lets bank_hi reach the fixed 0000-3FFF window too.
    if (A[14]) rom_bank = {bank_hi, bank_lo};
    else       rom_bank = mode ? {bank_hi, 5'd0} : 7'd0;
    rom_full = {rom_bank, A[13:0]};
    ram_bank = (mode ? bank_hi : 2'd0) & RAM_MASK;
    sram_on  = ram_en && HAS_SRAM;

    Di = OPEN_BUS;
    if (!cs_n && !rd_n) begin
      case (rgn)
        RGN_ROM0, RGN_ROMX: Di = rom_data;
        RGN_SRAM:           Di = sram_on ? ram_data : OPEN_BUS;
        RGN_WRAM:           Di = wram_data;
        default:            Di = OPEN_BUS;
      endcase
    end
  end

  assign rom_addr  = rom_full[ROM_AW-1:0];
  assign ram_addr  = {ram_bank[RAM_AW-14:0], A[12:0]};
  assign wram_addr = A[12:0];
  assign ram_we    = commit && (rgn == RGN_SRAM) && sram_on;
  assign wram_we   = commit && (rgn == RGN_WRAM);

`ifdef GB_MAPPER_DBG_EN
  assign dbg_rom_bank = {bank_hi, bank_lo};
  assign dbg_ram_en   = ram_en;
  assign dbg_mode     = mode;
`endif

endmodule

// File: tb/tb_gb_cart_mapper.sv
// Bench for gb_cart_mapper: directed vector table, multi-cycle corner sequences, randomized bus traffic vs a model.
module tb_gb_cart_mapper;

  localparam int ROM_BANKS = 128;
  localparam int RAM_BANKS = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] A = 16'h0000;
  logic [7:0]  Do = 8'h00;
  logic        wr_n = 1'b1, rd_n = 1'b1, cs_n = 1'b1;
  logic [7:0]  Di;
  logic [20:0] rom_addr;
  logic [7:0]  rom_data = 8'h00, ram_data = 8'h00, wram_data = 8'h00;
  logic [14:0] ram_addr;
  logic        ram_we, wram_we;
  logic [12:0] wram_addr;
`ifdef GB_MAPPER_DBG_EN
  logic [6:0]  dbg_rom_bank;
  logic        dbg_ram_en, dbg_mode;
  logic [15:0] dbg_wr_cnt;
`endif

  gb_cart_mapper #(.ROM_BANKS(ROM_BANKS), .RAM_BANKS(RAM_BANKS)) dut (
    .clock(clock), .reset(reset), .A(A), .Do(Do), .wr_n(wr_n), .rd_n(rd_n), .cs_n(cs_n),
    .Di(Di), .rom_addr(rom_addr), .rom_data(rom_data), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_we(ram_we), .wram_addr(wram_addr), .wram_data(wram_data), .wram_we(wram_we)
`ifdef GB_MAPPER_DBG_EN
    , .dbg_rom_bank(dbg_rom_bank), .dbg_ram_en(dbg_ram_en), .dbg_mode(dbg_mode), .dbg_wr_cnt(dbg_wr_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Strobe monitor, sampled mid-cycle.
  int ram_we_cnt = 0, wram_we_cnt = 0;
  int last_ram_addr = 0, last_wram_addr = 0;
  always @(negedge clock) begin
    if (ram_we)  begin ram_we_cnt++;  last_ram_addr  = int'(ram_addr);  end
    if (wram_we) begin wram_we_cnt++; last_wram_addr = int'(wram_addr); end
  end

  // Reference model state, held as plain integers.
  int m_ram_en, m_bank_lo, m_bank_hi, m_mode, m_wr_cnt;

  task automatic model_reset();
    m_ram_en = 0; m_bank_lo = 1; m_bank_hi = 0; m_mode = 0; m_wr_cnt = 0;
  endtask

  task automatic model_write(input int a, input int d);
    if (a < 'h8000) begin
      case (a / 'h2000)
        0: m_ram_en  = (d % 16 == 10) ? 1 : 0;
        1: m_bank_lo = (d % 32 == 0) ? 1 : d % 32;
        2: m_bank_hi = d % 4;
        default: m_mode = d % 2;
      endcase
      m_wr_cnt = (m_wr_cnt + 1) % 65536;
    end
  endtask

  function automatic int exp_rom(input int a);
    int bank;
    if (a < 'h4000) bank = m_mode ? m_bank_hi * 32 : 0;
    else            bank = m_bank_hi * 32 + m_bank_lo;
    return (bank * 16384 + a % 16384) % (ROM_BANKS * 16384);
  endfunction

  function automatic int exp_ram(input int a);
    return ((m_mode ? m_bank_hi : 0) % RAM_BANKS) * 8192 + a % 8192;
  endfunction

  function automatic int exp_di(input int a, input int r, input int s, input int w);
    if (a < 'h8000) return r;
    if (a < 'hA000) return 'hFF;
    if (a < 'hC000) return (m_ram_en != 0) ? s : 'hFF;
    if (a < 'hFE00) return w;
    return 'hFF;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    A = a; Do = d; cs_n = 1'b0; wr_n = 1'b0;
    repeat (hold) tick();
    wr_n = 1'b1; cs_n = 1'b1;
    tick();
    model_write(int'(a), int'(d));
  endtask

  // Read and check the region-specific address plus Di against the model.
  task automatic model_read(input string tag, input logic [15:0] a);
    int ai;
    ai = int'(a);
    A = a; cs_n = 1'b0; rd_n = 1'b0;
    rom_data = 8'($urandom); ram_data = 8'($urandom); wram_data = 8'($urandom);
    #1;
    if (ai < 'h8000) chk({tag, " rom_addr"}, 32'(rom_addr), 32'(exp_rom(ai)));
    else if (ai >= 'hA000 && ai < 'hC000) chk({tag, " ram_addr"}, 32'(ram_addr), 32'(exp_ram(ai)));
    else if (ai >= 'hC000 && ai < 'hFE00) chk({tag, " wram_addr"}, 32'(wram_addr), 32'(ai % 8192));
    chk({tag, " Di"}, 32'(Di), 32'(exp_di(ai, int'(rom_data), int'(ram_data), int'(wram_data))));
`ifdef GB_MAPPER_DBG_EN
    chk({tag, " dbg_wr_cnt"}, 32'(dbg_wr_cnt), 32'(m_wr_cnt));
`endif
    rd_n = 1'b1; cs_n = 1'b1;
    tick();
  endtask

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [7:0]  dat;
    bit          chk_rom;
    logic [20:0] exp_rom;
    logic [7:0]  exp_di;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int r0, w0;
    model_reset();

    vecs.push_back('{0, 16'h0150, 8'h3C, 1, 21'h00150, 8'h3C});
    vecs.push_back('{0, 16'h4000, 8'h11, 1, 21'h04000, 8'h11});
    vecs.push_back('{1, 16'h2000, 8'h00, 0, 21'h0,     8'h00});
    vecs.push_back('{0, 16'h4123, 8'h22, 1, 21'h04123, 8'h22});
    vecs.push_back('{1, 16'h2000, 8'h05, 0, 21'h0,     8'h00});
    vecs.push_back('{0, 16'h4123, 8'h33, 1, 21'h14123, 8'h33});
    vecs.push_back('{1, 16'h4000, 8'h01, 0, 21'h0,     8'h00});
    vecs.push_back('{1, 16'h6000, 8'h01, 0, 21'h0,     8'h00});
    vecs.push_back('{0, 16'h0010, 8'h44, 1, 21'h80010, 8'h44});
    vecs.push_back('{1, 16'h6000, 8'h00, 0, 21'h0,     8'h00});
    vecs.push_back('{0, 16'h0010, 8'h45, 1, 21'h00010, 8'h45});
    vecs.push_back('{0, 16'h7FFF, 8'h46, 1, 21'h97FFF, 8'h46});
    vecs.push_back('{1, 16'h2000, 8'hE0, 0, 21'h0,     8'h00});
    vecs.push_back('{0, 16'h4000, 8'h47, 1, 21'h84000, 8'h47});
    vecs.push_back('{0, 16'h8000, 8'h48, 0, 21'h0,     8'hFF});
    vecs.push_back('{0, 16'hA000, 8'h49, 0, 21'h0,     8'hFF});
    vecs.push_back('{0, 16'hFE00, 8'h4A, 0, 21'h0,     8'hFF});
    vecs.push_back('{0, 16'hFFFF, 8'h4A, 0, 21'h0,     8'hFF});
    vecs.push_back('{0, 16'hC000, 8'h4A, 0, 21'h0,     8'hC3});
    vecs.push_back('{0, 16'hFDFF, 8'h4A, 0, 21'h0,     8'hC3});
    vecs.push_back('{1, 16'h0000, 8'h0A, 0, 21'h0,     8'h00});
    vecs.push_back('{0, 16'hA000, 8'h4A, 0, 21'h0,     8'h5A});
    vecs.push_back('{1, 16'h1FFF, 8'h1B, 0, 21'h0,     8'h00});
    vecs.push_back('{0, 16'hBFFF, 8'h4A, 0, 21'h0,     8'hFF});
    vecs.push_back('{1, 16'h1000, 8'hFA, 0, 21'h0,     8'h00});
    vecs.push_back('{0, 16'hBFFF, 8'h4A, 0, 21'h0,     8'h5A});
    vecs.push_back('{1, 16'h6000, 8'hFE, 0, 21'h0,     8'h00});
    vecs.push_back('{0, 16'h3FFF, 8'h4B, 1, 21'h03FFF, 8'h4B});

    // Reset state, including a write attempt while reset is held.
    #1;
    chk("reset Di", 32'(Di), 32'hFF);
    chk("reset rom_addr", 32'(rom_addr), 32'h0);
    chk("reset ram_we", 32'(ram_we), 32'h0);
    A = 16'hC000; cs_n = 1'b0; wr_n = 1'b0;
    #1;
    chk("reset wram_we", 32'(wram_we), 32'h0);
`ifdef GB_MAPPER_DBG_EN
    chk("reset dbg_wr_cnt", 32'(dbg_wr_cnt), 32'h0);
`endif
    wr_n = 1'b1; cs_n = 1'b1; A = 16'h0000;
    tick();
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        bus_write(vecs[i].addr, vecs[i].dat, 1);
      end else begin
        A = vecs[i].addr; cs_n = 1'b0; rd_n = 1'b0;
        rom_data = vecs[i].dat; ram_data = 8'h5A; wram_data = 8'hC3;
        #1;
        if (vecs[i].chk_rom) chk($sformatf("vec%0d rom_addr", i), 32'(rom_addr), 32'(vecs[i].exp_rom));
        chk($sformatf("vec%0d Di", i), 32'(Di), 32'(vecs[i].exp_di));
        rd_n = 1'b1; cs_n = 1'b1;
        tick();
      end
    end

    // SRAM: disabled writes make no strobe; enabled banked write makes exactly one.
    bus_write(16'h0000, 8'h00, 1);
    r0 = ram_we_cnt;
    bus_write(16'hA000, 8'h12, 1);
    chk("sram disabled we count", 32'(ram_we_cnt - r0), 32'd0);
    model_read("sram disabled", 16'hA000);
    bus_write(16'h0000, 8'h0A, 1);
    bus_write(16'h6000, 8'h01, 1);
    bus_write(16'h4000, 8'h02, 1);
    r0 = ram_we_cnt;
    bus_write(16'hA001, 8'h55, 1);
    chk("sram we count", 32'(ram_we_cnt - r0), 32'd1);
    chk("sram we addr", 32'(last_ram_addr), 32'h4001);

    // Echo WRAM write held low for five cycles.
    w0 = wram_we_cnt;
    bus_write(16'hE010, 8'h77, 5);
    chk("wram long we count", 32'(wram_we_cnt - w0), 32'd1);
    chk("wram long we addr", 32'(last_wram_addr), 32'h0010);

    // Reset in the middle of a held write to bank_hi, with a read on the bus too.
    bus_write(16'h2000, 8'h05, 1);
    A = 16'h4000; Do = 8'h03; cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0;
    tick();
    chk("midwrite rom_addr", 32'(rom_addr), 32'h194000);
    tick();
    chk("midwrite held rom_addr", 32'(rom_addr), 32'h194000);
    reset = 1'b1;
    #1;
    chk("in reset rom_addr", 32'(rom_addr), 32'h04000);
`ifdef GB_MAPPER_DBG_EN
    chk("in reset dbg_wr_cnt", 32'(dbg_wr_cnt), 32'h0);
`endif
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    chk("post reset commit rom_addr", 32'(rom_addr), 32'h184000);
    tick();
    chk("post reset single commit", 32'(rom_addr), 32'h184000);
    wr_n = 1'b1; rd_n = 1'b1; cs_n = 1'b1;
    tick();
    model_write('h4000, 'h03);
    model_read("after reset sram", 16'hA000);
    model_read("after reset rom0", 16'h0123);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int sel, hold;
      logic [15:0] a;
      logic [7:0]  d;
      sel = $urandom_range(0, 9);
      hold = $urandom_range(1, 3);
      d = 8'($urandom);
      if (sel <= 5) begin
        if (sel <= 3) a = 16'($urandom_range(0, 'h7FFF));
        else          a = 16'($urandom_range('hA000, 'hFDFF));
        if (a < 16'h2000 && d[0]) d[3:0] = 4'hA;
        r0 = ram_we_cnt; w0 = wram_we_cnt;
        bus_write(a, d, hold);
        chk("rand ram_we count", 32'(ram_we_cnt - r0),
            32'((a >= 16'hA000 && a < 16'hC000 && m_ram_en != 0) ? 1 : 0));
        chk("rand wram_we count", 32'(wram_we_cnt - w0),
            32'((a >= 16'hC000 && a < 16'hFE00) ? 1 : 0));
        if (a >= 16'hA000 && a < 16'hC000 && m_ram_en != 0)
          chk("rand ram_we addr", 32'(last_ram_addr), 32'(exp_ram(int'(a))));
        if (a >= 16'hC000 && a < 16'hFE00)
          chk("rand wram_we addr", 32'(last_wram_addr), 32'(int'(a) % 8192));
      end else begin
        model_read("rand read", 16'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
